// File: rtl/fft_bfly_pipe_if.sv
// Handshake and data bundle for the pipelined radix-2 butterfly.
// The DUT uses the slave modport; the upstream/downstream side uses master.
interface fft_bfly_pipe_if #(
  parameter int DW   = 16,
  parameter int TW   = 16,
  parameter int TAGW = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [2*DW-1:0] a_i;
  logic [2*DW-1:0] b_i;
  logic [2*TW-1:0] w_i;
  logic            scale_i;
  logic [TAGW-1:0] tag_i;
  logic            out_valid;
  logic            out_ready;
  logic [2*DW-1:0] y_o;
  logic [2*DW-1:0] z_o;
  logic [TAGW-1:0] tag_o;
  logic            ovf_o;
  logic            ovf_clr;

  modport master (
    output in_valid, a_i, b_i, w_i, scale_i, tag_i, out_ready, ovf_clr,
    input  in_ready, out_valid, y_o, z_o, tag_o, ovf_o
  );

  modport slave (
    input  in_valid, a_i, b_i, w_i, scale_i, tag_i, out_ready, ovf_clr,
    output in_ready, out_valid, y_o, z_o, tag_o, ovf_o
  );
endinterface

// File: rtl/fft_bfly_pipe.sv
// 3-stage radix-2 DIT butterfly: Y = A + B*w, Z = A - B*w, with scaling and saturation.
// Define BFLY_ROUND_EN to make both right shifts round half-up instead of truncating.
module fft_bfly_pipe #(
  parameter int DW   = 16,
  parameter int TW   = 16,
  parameter int TAGW = 8
) (
  input  logic           Clk,
  input  logic           Rst,
  fft_bfly_pipe_if.slave bus
);

  localparam int PW = DW + TW;   // full product width
  localparam int SW = DW + 2;    // aligned B*w width
  localparam int RW = DW + 3;    // sum/difference width

`ifdef BFLY_ROUND_EN
  localparam logic RND = 1'b1;
`else
  localparam logic RND = 1'b0;
`endif

  logic adv;
  logic v1, v2, v3;

  logic signed [PW-1:0] brx, bix, wrx, wix;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic [2*DW-1:0]      a1, a2;
  logic                 sc1, sc2;
  logic [TAGW-1:0]      tag1, tag2, tag3;

  logic [PW:0]          bwr_full, bwi_full;
  logic [SW-1:0]        bwr2, bwi2;

  logic [DW:0]          fyr, fyi, fzr, fzi;
  logic                 sat_any;
  logic [2*DW-1:0]      y3, z3;
  logic                 ovf;

  assign adv          = bus.out_ready | ~v3;
  assign bus.in_ready = adv;

  // Operands sign-extended to product width so the multiplies are full precision.
  assign brx = $signed({{TW{bus.b_i[2*DW-1]}}, bus.b_i[2*DW-1:DW]});
  assign bix = $signed({{TW{bus.b_i[DW-1]}},   bus.b_i[DW-1:0]});
  assign wrx = $signed({{DW{bus.w_i[2*TW-1]}}, bus.w_i[2*TW-1:TW]});
  assign wix = $signed({{DW{bus.w_i[TW-1]}},   bus.w_i[TW-1:0]});

  assign bwr_full = {p_rr[PW-1], p_rr} - {p_ii[PW-1], p_ii};
  assign bwi_full = {p_ri[PW-1], p_ri} + {p_ir[PW-1], p_ir};

  // Shift Q1.(TW-1) scaled product back to A's format.
  function automatic logic [SW-1:0] align(input logic [PW:0] x);
    logic [PW+1:0] t;
    t = {x[PW], x} + ((PW+2)'(RND) << (TW-2));
    return t[PW:TW-1];
  endfunction

  // Returns {saturated, result} for A +/- Bw with optional halving.
  function automatic logic [DW:0] sum_sat(input logic [DW-1:0] a,
                                          input logic [SW-1:0] bw,
                                          input logic          sub,
                                          input logic          sc);
    logic [RW-1:0] ae, be, s, t, r;
    ae = {{3{a[DW-1]}}, a};
    be = {bw[SW-1], bw};
    s  = sub ? (ae - be) : (ae + be);
    t  = s + RW'(RND);
    r  = sc ? {t[RW-1], t[RW-1:1]} : s;
    if (r[RW-1:DW-1] == '0 || r[RW-1:DW-1] == '1)
      return {1'b0, r[DW-1:0]};
    else if (r[RW-1])
      return {1'b1, 1'b1, {(DW-1){1'b0}}};
    else
      return {1'b1, 1'b0, {(DW-1){1'b1}}};
  endfunction

  assign fyr = sum_sat(a2[2*DW-1:DW], bwr2, 1'b0, sc2);
  assign fyi = sum_sat(a2[DW-1:0],    bwi2, 1'b0, sc2);
  assign fzr = sum_sat(a2[2*DW-1:DW], bwr2, 1'b1, sc2);
  assign fzi = sum_sat(a2[DW-1:0],    bwi2, 1'b1, sc2);

  assign sat_any = v2 & (fyr[DW] | fyi[DW] | fzr[DW] | fzi[DW]);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      v3   <= 1'b0;
      p_rr <= '0;
      p_ii <= '0;
      p_ri <= '0;
      p_ir <= '0;
      a1   <= '0;
      a2   <= '0;
      sc1  <= 1'b0;
      sc2  <= 1'b0;
      tag1 <= '0;
      tag2 <= '0;
      tag3 <= '0;
      bwr2 <= '0;
      bwi2 <= '0;
      y3   <= '0;
      z3   <= '0;
      ovf  <= 1'b0;
    end else begin
      if (adv) begin
        v1   <= bus.in_valid;
        p_rr <= brx * wrx;
        p_ii <= bix * wix;
        p_ri <= brx * wix;
        p_ir <= bix * wrx;
        a1   <= bus.a_i;
        sc1  <= bus.scale_i;
        tag1 <= bus.tag_i;

        v2   <= v1;
        bwr2 <= align(bwr_full);
        bwi2 <= align(bwi_full);
        a2   <= a1;
        sc2  <= sc1;
        tag2 <= tag1;

        v3   <= v2;
        y3   <= {fyr[DW-1:0], fyi[DW-1:0]};
        z3   <= {fzr[DW-1:0], fzi[DW-1:0]};
        tag3 <= tag2;
      end
      // A saturating result being loaded overrides a clear request.
      if (adv && sat_any)
        ovf <= 1'b1;
      else if (bus.ovf_clr)
        ovf <= 1'b0;
    end
  end

  assign bus.out_valid = v3;
  assign bus.y_o       = y3;
  assign bus.z_o       = z3;
  assign bus.tag_o     = tag3;
  assign bus.ovf_o     = ovf;

endmodule

// File: doc/fft_bfly_pipe.md
Name: fft_bfly_pipe

Overview:
- Parametrised, pipelined radix-2 DIT butterfly for the FFT datapath. It is the next generation of the fixed 16-bit multiply-add unit.
- Computes Y = A + B*w and Z = A - B*w on packed complex operands.
- Adds valid/ready flow control, per-transaction scaling by 1/2, saturation with a sticky overflow flag, and a sideband tag.
- Sits between the stage sample memory / twiddle ROM and the stage write-back logic.

Parameters:
- DW, 16: width of each real/imag component of A, B, Y, Z; two's complement.
- TW, 16: width of each twiddle component; signed Q1.(TW-1).
- TAGW, 8: width of the sideband tag (butterfly index / address) passed alongside data.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  asynchronous active-high reset.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block accepts input this cycle.
- a_i  in  2*DW  operand A; {real[2*DW-1:DW], imag[DW-1:0]}.
- b_i  in  2*DW  operand B; same packing.
- w_i  in  2*TW  twiddle; {real, imag}.
- scale_i  in  1  1 = divide results by 2; captured with the transaction.
- tag_i  in  TAGW  sideband, returned unchanged.
- out_valid  out  1  Y/Z/tag valid.
- out_ready  in  1  downstream accepts output.
- y_o  out  2*DW  A + B*w, packed.
- z_o  out  2*DW  A - B*w, packed.
- tag_o  out  TAGW  tag of this result.
- ovf_o  out  1  sticky: saturation occurred since last clear.
- ovf_clr  in  1  clears ovf_o.

Behaviour:
- Clock and reset: one clock, Clk. Rst is asynchronous and active-high.
- Reset values: all stage valid bits 0, out_valid 0, y_o/z_o/tag_o 0, ovf_o 0. Rst mid-operation discards every in-flight transaction; nothing is emitted afterwards.
- Pipeline: 3 stages, S1 -> S2 -> S3 (S3 = output registers). Latency is exactly 3 cycles from an accepted input to out_valid when not stalled.
- Global advance: adv = out_ready | ~out_valid. All stage registers, including valid bits, load only when adv = 1. in_ready = adv.
  - A stalled pipe holds all in-flight data intact.
  - Bubbles are not collapsed.
  - Full throughput is one butterfly per cycle.
- Transfers: input is accepted when in_valid & in_ready; output is consumed when out_valid & out_ready.
- out_valid stability: out_valid must not drop, and y_o/z_o/tag_o must not change, while out_valid=1 and out_ready=0.
- S1: register the four full-precision products Br*wr, Bi*wi, Br*wi, Bi*wr (DW+TW bits each); delay A, scale, tag.
- S2:
  - Bwr = Br*wr - Bi*wi and Bwi = Br*wi + Bi*wr, each DW+TW+1 bits.
  - Align to A's format with an arithmetic right shift by TW-1, giving DW+2 bits. This shift uses the rounding mode below.
- S3:
  - Sum and difference at DW+3 bits, with A sign-extended.
  - If scale=1: arithmetic right shift by 1, using the same rounding mode.
  - Saturate each component to [-2^(DW-1), 2^(DW-1)-1].
- Rounding mode: floor (truncate), unless BFLY_ROUND_EN is defined.
- Overflow flag: ovf_o sets in the cycle an S3 result that saturated is loaded. Set wins over a simultaneous ovf_clr. ovf_clr alone clears ovf_o next cycle.
- Special case: w = (-2^(TW-1), 0) is legal; products must not overflow the internal widths.

Optional Feature:
- Macro: BFLY_ROUND_EN.
- Defined: both right shifts (the S2 alignment and the S3 scale) round half-up. Add 2^(k-1) before shifting by k.
- Undefined: both shifts truncate toward negative infinity.
- Latency and interface are identical in both builds.

Test Plan:
All scenarios use DW=TW=16 and out_ready=1 unless stated.
- Real twiddle: A=(1000,-2000), B=(4000,2000), w=(16384,0), scale=0 -> three cycles later Y=(3000,-1000), Z=(-1000,-3000), ovf_o=0.
- Imaginary twiddle: A=(0,0), B=(4000,2000), w=(0,16384) -> Y=(-1000,2000), Z=(1000,-2000). Repeat with scale=1 -> Y=(-500,1000), Z=(500,-1000).
- Saturation: A=(32767,0), B=(32767,0), w=(32767,0) -> Y.real=32767 (saturated), Z.real=1, ovf_o=1 and held. Then ovf_clr=1 for one cycle -> ovf_o=0. Also assert ovf_clr in the same cycle as a new saturating result -> ovf_o stays 1.
- Rounding: A=(0,0), B=(3,0), w=(16384,0) -> Y.real=1 without BFLY_ROUND_EN, 2 with it. Y.imag=0 in both builds.
- Backpressure: stream 5 tagged inputs (tags 1..5), out_ready=0 from cycle 3 for 4 cycles -> in_ready=0 while stalled, out_valid and y_o held. Order 1..5 is preserved with no loss or duplication.
- Reset mid-stream: assert Rst while 3 transactions are in flight -> out_valid=0 immediately and no stale outputs after release.
